load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 66 ++++++
 rtl/lsu_load_ext.sv | 26 ++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: size encodings, FSM states,
// byte-enable constants and lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    LOAD_CAP,
    RESP
  } lsu_state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Encoding 2'b11 is folded into a word access.
  function automatic lsu_size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

  // Low address bits that survive alignment for a given size.
  function automatic logic [1:0] keep_mask(input lsu_size_e sz);
    case (sz)
      SZ_BYTE: return 2'b11;
      SZ_HALF: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input lsu_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return BE_BYTE0 << lo;
      SZ_HALF: return lo[1] ? BE_HALF_HI : BE_HALF_LO;
      default: return BE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input lsu_size_e sz, input logic [31:0] wd);
    case (sz)
      SZ_BYTE: return {4{wd[7:0]}};
      SZ_HALF: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load-data lane selection and sign/zero extension (purely combinational).
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  lsu_size_e   size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    data_o   = '0;
    byte_sel = mem_rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: data_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one outstanding access, single-cycle memory strobe.
// Define LSU_MISALIGN_CHK_EN to flag misaligned accesses instead of aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misalign,
  output logic                  mem_RD,
  output logic                  mem_WR,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_byte_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  lsu_size_e             size_q, size_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] ext_data;
  lsu_size_e             req_sz;
`ifdef LSU_MISALIGN_CHK_EN
  logic                  mis_q, mis_d;
`endif

  lsu_load_ext u_load_ext (
    .mem_rdata_i (mem_rdata),
    .size_i      (size_q),
    .addr_lo_i   (addr_q[1:0]),
    .unsigned_i  (uns_q),
    .data_o      (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef LSU_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    req_sz  = decode_size(req_size);
`ifdef LSU_MISALIGN_CHK_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = req_sz;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rdata_d = '0;
`ifdef LSU_MISALIGN_CHK_EN
          addr_d  = req_addr;
          mis_d   = is_misaligned(req_sz, req_addr[1:0]);
          state_d = is_misaligned(req_sz, req_addr[1:0]) ? RESP : ACCESS;
`else
          // Offending low bits are dropped so the access lands on the aligned container.
          addr_d  = {req_addr[ADDR_WIDTH-1:2], req_addr[1:0] & keep_mask(req_sz)};
          state_d = ACCESS;
`endif
        end
      end
      ACCESS:   state_d = we_q ? RESP : LOAD_CAP;
      LOAD_CAP: begin
        rdata_d = ext_data;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
`ifdef LSU_MISALIGN_CHK_EN
          mis_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rst_n gating keeps req_ready low while reset is held.
  assign req_ready   = rst_n && (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
`ifdef LSU_MISALIGN_CHK_EN
  assign resp_misalign = mis_q;
`else
  assign resp_misalign = 1'b0;
`endif

  assign mem_RD      = (state_q == ACCESS) && !we_q;
  assign mem_WR      = (state_q == ACCESS) && we_q;
  assign mem_addr    = addr_q;
  assign mem_byte_en = (state_q == ACCESS) ? byte_enable(size_q, addr_q[1:0]) : BE_NONE;
  assign mem_wdata   = (state_q == ACCESS) ? lane_replicate(size_q, wdata_q) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, decoupled monitors.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        mem_RD, mem_WR;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byte_en;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .mem_RD(mem_RD), .mem_WR(mem_WR), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          acc;
  } exp_resp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_acc_t;

  exp_resp_t resp_q[$];
  exp_acc_t  acc_q[$];
  logic [7:0] ref_mem [256];
  logic [31:0] tbmem [64];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_tok = 0;

  function automatic logic [31:0] init_word(input int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory seen by the DUT: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (!rst_n && cyc < 4) begin
      for (int i = 0; i < 64; i++) tbmem[i] <= init_word(i);
    end else begin
      if (mem_WR)
        for (int b = 0; b < 4; b++)
          if (mem_byte_en[b]) tbmem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_RD) mem_rdata <= tbmem[mem_addr[7:2]];
    end
  end

  // Memory-side monitor.
  always @(negedge clk) begin
    exp_acc_t ea;
    if (rst_n) begin
      if (mem_RD || mem_WR) begin
        chk("single_strobe", 32'(mem_RD & mem_WR), 32'd0);
        if (acc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_strobe: got RD=%0b WR=%0b addr=%08h expected none", mem_RD, mem_WR, mem_addr);
        end else begin
          ea = acc_q.pop_front();
          chk("strobe_kind", 32'(mem_WR), 32'(ea.wr));
          chk("mem_addr", mem_addr, ea.addr);
          chk("mem_byte_en", 32'(mem_byte_en), 32'(ea.be));
          if (ea.wr) chk("mem_wdata", mem_wdata, ea.wdata);
        end
      end else begin
        chk("idle_byte_en", 32'(mem_byte_en), 32'd0);
      end
    end
  end

  // Response-side monitor; also owns resp_ready.
  bit          in_resp = 0, hs_pend = 0;
  int          stall_cnt = 0, stall_done = 0;
  logic [31:0] held_rdata;
  logic        held_mis;
  always @(negedge clk) begin
    exp_resp_t er;
    if (!rst_n) begin
      in_resp = 0; hs_pend = 0;
    end else if (hs_pend) begin
      chk("resp_valid_drop", 32'(resp_valid), 32'd0);
      hs_pend = 0; in_resp = 0;
    end else if (resp_valid) begin
      if (!in_resp) begin
        in_resp = 1;
        if (stall_tok != stall_done) begin stall_cnt = 5; stall_done = stall_tok; end
        if (resp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_resp: got rdata=%08h expected no response", resp_rdata);
        end else begin
          er = resp_q.pop_front();
          chk("latency", 32'(cyc - er.acc), 32'(er.lat));
          chk("resp_rdata", resp_rdata, er.rdata);
          chk("resp_misalign", 32'(resp_misalign), 32'(er.mis));
        end
        held_rdata = resp_rdata;
        held_mis   = resp_misalign;
      end else begin
        chk("hold_rdata", resp_rdata, held_rdata);
        chk("hold_misalign", 32'(resp_misalign), 32'(held_mis));
      end
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (stall_cnt > 0) begin resp_ready = 1'b0; stall_cnt--; end
      else resp_ready = ($urandom_range(0, 3) != 0);
      if (resp_ready) hs_pend = 1;
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input bit hold_bogus);
    int nb, off, w;
    logic [31:0] eff;
    longint unsigned v;
    exp_resp_t er;
    exp_acc_t ea;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = int'(addr % 32'(nb));
    er.acc = cyc;
`ifdef LSU_MISALIGN_CHK_EN
    if (off != 0) begin
      er.rdata = '0; er.mis = 1'b1; er.lat = 1;
    end else
`endif
    begin
      eff = addr - 32'(off);
      ea.wr = we; ea.addr = eff;
      ea.be = 4'(((1 << nb) - 1) << (eff % 4));
      for (int i = 0; i < 4; i++) ea.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
      acc_q.push_back(ea);
      er.mis = 1'b0;
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[eff[7:0] + 8'(i)] = wd[8*i +: 8];
        er.rdata = '0; er.lat = 2;
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[eff[7:0] + 8'(i)]) << (8 * i));
        if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 1);
        er.rdata = v[31:0]; er.lat = 3;
      end
    end
    resp_q.push_back(er);
    @(negedge clk);
    if (hold_bogus) begin
      stall_tok++;
      req_we = ~we; req_addr = 32'h20; req_size = 2'b10; req_wdata = 32'hBAD0BAD0;
      repeat (6) @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    int w;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      t = init_word(i / 4);
      ref_mem[i] = t[8*(i%4) +: 8];
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_mis", 32'(resp_misalign), 32'd0);
    chk("rst_mem_strobes", 32'({mem_RD, mem_WR}), 32'd0);
    chk("rst_mem_be", 32'(mem_byte_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 32'(req_ready), 32'd1);

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 0);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 0);
    issue(1'b1, 2'b11, 1'b0, 32'h23, 32'h12345678, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h15, 32'h0, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1);

    for (int n = 0; n < 200; n++)
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom, 0);

    // Reset while a load is in its memory-access cycle.
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    chk("abort_mem_RD", 32'(mem_RD), 32'd0);
    chk("abort_mem_be", 32'(mem_byte_en), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    resp_q.delete();
    acc_q.delete();
    rst_n = 1'b1;
    #1 chk("abort_release_ready", 32'(req_ready), 32'd1);
    repeat (10) @(negedge clk);

    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    w = 0;
    while (resp_q.size() != 0 && w < 50) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
    chk("acc_q_empty", 32'(acc_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
